// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Purpose    : receive FIFO between the buart receiver and the j1 IO read mux;
//              drains buart bytes into a 2**AW x 8 circular buffer.
// Latency    : a byte offered in cycle n is written at the end of cycle n and
//              visible on q/nonempty/count in cycle n+1; uart_rd is high in n+1.
// Backpressure: while full, the byte stays held in buart (uart_rd is not
//              pulsed) and the sticky stalled flag is set. At most one byte is
//              accepted every 2 cycles.
//
// Ports:
//   clk        system clock
//   resetq     asynchronous active-low reset
//   uart_valid buart has a byte; held until acknowledged
//   uart_data  buart byte; stable while uart_valid is high
//   uart_rd    one-cycle acknowledge pulse back to buart
//   pop        CPU read strobe of the data register; ignored while empty
//   flush      empty the FIFO, clear peak and stalled; wins over write and pop
//   q          head byte (show-ahead); meaningful only when nonempty=1
//   nonempty   at least one byte stored
//   full       2**AW bytes stored
//   count      current occupancy, 0..2**AW
//   peak       highest occupancy since reset or flush
//   stalled    sticky: a byte had to wait in buart because the FIFO was full
module uart_rx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          uart_valid,
  input  logic [7:0]    uart_data,
  output logic          uart_rd,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    q,
  output logic          nonempty,
  output logic          full,
  output logic [AW:0]   count,
  output logic [AW:0]   peak,
  output logic          stalled
);

  localparam int DEPTH = 2**AW;

  // One-hot ingress states. uart_rd is the ACK bit itself, so it is glitch-free
  // and drops immediately on the asynchronous reset.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic [AW:0] r_peak;
  logic        r_stalled;
  logic [7:0]  r_mem [DEPTH];

  logic        w_empty;
  logic        w_full;
  logic        w_wr;
  logic        w_pop;
  logic        w_stall_set;
  logic [AW:0] w_count;
  logic [AW:0] w_wp_next;
  logic [AW:0] w_rp_next;
  logic [AW:0] w_count_next;
  logic [AW:0] w_peak_next;
  logic        w_stalled_next;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign w_count = r_wp - r_rp;

  // ---------------------------------------------------------------------------
  // Ingress FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ACK exists only to skip the cycle in which buart still shows the byte that
  // was just taken (it drops valid one cycle after seeing rd). Flush blocks the
  // write and, since ACK always falls back to IDLE, also returns the FSM there.
  always_comb begin
    w_state_next = r_state;
    w_wr         = 1'b0;
    w_stall_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (uart_valid && !flush) begin
          if (!w_full) begin
            w_wr         = 1'b1;
            w_state_next = ST_ACK;
          end else begin
            w_stall_set  = 1'b1;
          end
        end
      end
      ST_ACK: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign uart_rd = (r_state == ST_ACK);

  // ---------------------------------------------------------------------------
  // Pointer, occupancy and flag update
  // ---------------------------------------------------------------------------
  // Write is gated by the full flag seen before the edge, so a pop in the same
  // cycle as a full FIFO does not let a write in until the following cycle.
  always_comb begin
    w_pop          = pop && !w_empty && !flush;
    w_wp_next      = r_wp + {{AW{1'b0}}, w_wr};
    w_rp_next      = flush ? r_wp : (r_rp + {{AW{1'b0}}, w_pop});
    w_count_next   = w_wp_next - w_rp_next;
    w_peak_next    = r_peak;
    w_stalled_next = r_stalled | w_stall_set;
    if (flush) begin
      w_peak_next    = '0;
      w_stalled_next = 1'b0;
    end else if (w_count_next > r_peak) begin
      w_peak_next    = w_count_next;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_peak    <= '0;
      r_stalled <= 1'b0;
    end else begin
      r_wp      <= w_wp_next;
      r_rp      <= w_rp_next;
      r_peak    <= w_peak_next;
      r_stalled <= w_stalled_next;
    end
  end

  // Storage is not reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp[AW-1:0]] <= uart_data;
    end
  end

  // Show-ahead read straight from the registered read pointer.
  assign q        = r_mem[r_rp[AW-1:0]];
  assign nonempty = !w_empty;
  assign full     = w_full;
  assign count    = w_count;
  assign peak     = r_peak;
  assign stalled  = r_stalled;

endmodule
